// File: rtl/sn_write_queue.sv
// sn_write_queue: byte FIFO in front of an SN76489-style generator.
// Replays queued bytes on the nWE/nCE/D strobe and paces each one on READY.
module sn_write_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   nWE,
    output logic                   nCE,
    output logic [7:0]             D,
    input  logic                   READY
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RELEASE = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   wait_cnt;
    logic            push;
    logic            pop;
    logic            cnt_expired;

    // Occupancy-derived status; none of it looks at wr_valid directly.
    assign wr_ready    = (level != LW'(DEPTH));
    assign busy        = (state != IDLE) || (level != '0);
    assign push        = wr_valid && wr_ready;
    assign pop         = (state == IDLE) && (level != '0);
    assign cnt_expired = (wait_cnt == CW'(TIMEOUT));

    // Storage array: no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (nRST && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Strobe sequencer: STROBE waits for READY low, RELEASE waits for READY high.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            nWE         <= 1'b1;
            nCE         <= 1'b1;
            D           <= 8'h00;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        D        <= mem[rd_ptr];
                        nWE      <= 1'b0;
                        nCE      <= 1'b0;
                        wait_cnt <= '0;
                        state    <= STROBE;
                    end
                end
                STROBE: begin
                    if (!READY) begin
                        nWE      <= 1'b1;
                        nCE      <= 1'b1;
                        wait_cnt <= '0;
                        state    <= RELEASE;
                    end else if (cnt_expired) begin
                        // Generator never took the byte; drop it and move on.
                        nWE         <= 1'b1;
                        nCE         <= 1'b1;
                        wait_cnt    <= '0;
                        timeout_err <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (READY) begin
                        state <= GAP;
                    end else if (cnt_expired) begin
                        timeout_err <= 1'b1;
                        state       <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    nWE   <= 1'b1;
                    nCE   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn_write_queue.sv
// Directed self-checking bench for sn_write_queue with a simple READY generator model.
module tb_sn_write_queue;

    logic       CLK;
    logic       nRST;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] level;
    logic       busy;
    logic       timeout_err;
    logic       nWE;
    logic       nCE;
    logic [7:0] D;
    logic       READY;

    logic       resp_mode;
    logic       ready_force;

    int n_compared;
    int n_mismatched;

    logic [7:0] strobes [$];
    int  to_count;
    int  low_run;
    int  high_run;
    int  last_low_len;
    int  last_high_len;
    int  d_glitch;
    bit  prev_high;

    sn_write_queue #(.DEPTH(8), .TIMEOUT(63)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .level       (level),
        .busy        (busy),
        .timeout_err (timeout_err),
        .nWE         (nWE),
        .nCE         (nCE),
        .D           (D),
        .READY       (READY)
    );

    // Responsive generator answers in the same cycle: READY follows the strobe.
    assign READY = resp_mode ? nWE : ready_force;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Strobe monitor on the falling edge, away from the active edge.
    initial begin
        prev_high     = 1'b1;
        low_run       = 0;
        high_run      = 0;
        last_low_len  = 0;
        last_high_len = 0;
        to_count      = 0;
        d_glitch      = 0;
    end

    always @(negedge CLK) begin
        if (nWE === 1'b0) begin
            if (prev_high) begin
                strobes.push_back(D);
                last_high_len = high_run;
                low_run = 0;
            end else if (D !== strobes[$]) begin
                d_glitch++;
            end
            low_run++;
        end else begin
            if (!prev_high) begin
                last_low_len = low_run;
                high_run = 0;
            end
            high_run++;
        end
        if (timeout_err === 1'b1) to_count++;
        prev_high = (nWE !== 1'b0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        nRST        = 1'b0;
        wr_valid    = 1'b1;
        wr_data     = 8'h55;
        resp_mode   = 1'b0;
        ready_force = 1'b1;

        // Reset with a write request pending
        repeat (3) tick();
        check_eq("rst_nWE", 32'(nWE), 32'd1);
        check_eq("rst_nCE", 32'(nCE), 32'd1);
        check_eq("rst_D", 32'(D), 32'h00);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
        nRST     = 1'b1;
        wr_valid = 1'b0;
        tick();
        check_eq("rst_no_push", 32'(level), 32'd0);

        // Single write: READY drops 3 cycles into the strobe, returns 2 cycles later
        strobes.delete();
        to_count = 0;
        push_byte(8'h9F);
        check_eq("single_level_after_push", 32'(level), 32'd1);
        tick();
        check_eq("single_strobe_low", 32'(nWE), 32'd0);
        check_eq("single_nce_low", 32'(nCE), 32'd0);
        for (int idx = 0; idx < 10; idx++) begin
            ready_force = !(idx == 3 || idx == 4);
            tick();
        end
        ready_force = 1'b1;
        check_eq("single_strobe_count", 32'(strobes.size()), 32'd1);
        check_eq("single_D", 32'(strobes[0]), 32'h9F);
        check_eq("single_low_len", 32'(last_low_len), 32'd4);
        check_eq("single_no_timeout", 32'(to_count), 32'd0);
        check_eq("single_busy_clear", 32'(busy), 32'd0);
        check_eq("single_D_held", 32'(D), 32'h9F);

        // Full FIFO with READY stuck high
        strobes.delete();
        to_count = 0;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + i);
            tick();
        end
        check_eq("full_level_after_8", 32'(level), 32'd7);
        check_eq("full_ready_after_8", 32'(wr_ready), 32'd1);
        wr_data = 8'h18;
        tick();
        check_eq("full_level_after_9", 32'(level), 32'd8);
        check_eq("full_ready_after_9", 32'(wr_ready), 32'd0);
        wr_data = 8'h19;
        tick();
        check_eq("full_level_after_10", 32'(level), 32'd8);
        check_eq("full_ready_after_10", 32'(wr_ready), 32'd0);
        wr_data = 8'hAA;
        tick();
        wr_valid = 1'b0;
        check_eq("full_level_after_11", 32'(level), 32'd8);
        resp_mode = 1'b1;
        wait_idle("full_drain_done", 200);
        check_eq("full_drain_count", 32'(strobes.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < strobes.size())
                check_eq($sformatf("full_order_%0d", i), 32'(strobes[i]), 32'(8'h10 + i));
        end
        check_eq("full_no_timeout", 32'(to_count), 32'd0);

        // Ordering with a responsive generator
        strobes.delete();
        push_byte(8'h80);
        push_byte(8'h05);
        push_byte(8'hC3);
        push_byte(8'h12);
        wait_idle("order_drain_done", 100);
        check_eq("order_count", 32'(strobes.size()), 32'd4);
        if (strobes.size() == 4) begin
            check_eq("order_0", 32'(strobes[0]), 32'h80);
            check_eq("order_1", 32'(strobes[1]), 32'h05);
            check_eq("order_2", 32'(strobes[2]), 32'hC3);
            check_eq("order_3", 32'(strobes[3]), 32'h12);
        end
        check_eq("order_low_len", 32'(last_low_len), 32'd1);
        check_eq("order_gap_len", 32'(last_high_len), 32'd3);

        // Timeout with READY stuck high
        strobes.delete();
        to_count    = 0;
        resp_mode   = 1'b0;
        ready_force = 1'b1;
        push_byte(8'h90);
        push_byte(8'h01);
        for (int i = 0; i < 200; i++) begin
            if (strobes.size() >= 2) break;
            tick();
        end
        check_eq("to_second_strobe", 32'(strobes.size()), 32'd2);
        check_eq("to_low_len", 32'(last_low_len), 32'd64);
        check_eq("to_pulse_count", 32'(to_count), 32'd1);
        check_eq("to_gap_len", 32'(last_high_len), 32'd3);
        if (strobes.size() >= 2) begin
            check_eq("to_first_byte", 32'(strobes[0]), 32'h90);
            check_eq("to_second_byte", 32'(strobes[1]), 32'h01);
        end
        resp_mode = 1'b1;
        wait_idle("to_drain_done", 100);
        check_eq("to_single_pulse", 32'(to_count), 32'd1);

        // Reset in the middle of a strobe
        strobes.delete();
        resp_mode   = 1'b0;
        ready_force = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        check_eq("midrst_strobing", 32'(nWE), 32'd0);
        nRST = 1'b0;
        tick();
        check_eq("midrst_nWE", 32'(nWE), 32'd1);
        check_eq("midrst_nCE", 32'(nCE), 32'd1);
        check_eq("midrst_level", 32'(level), 32'd0);
        check_eq("midrst_D", 32'(D), 32'h00);
        nRST = 1'b1;
        begin
            int n0;
            n0 = strobes.size();
            repeat (20) tick();
            check_eq("midrst_no_more_strobes", 32'(strobes.size()), 32'(n0));
        end
        check_eq("midrst_idle_nWE", 32'(nWE), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);

        check_eq("d_stable_during_strobe", 32'(d_glitch), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
